// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone B3 classic initiator: valid/ready command in,
// one read/write cycle on the bus, data and status out on a valid/ready response.
module wb_master_bridge #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_cmd_valid,
   output logic            o_cmd_ready,
   input  logic            i_cmd_we,
   input  logic [AW-1:0]   i_cmd_adr,
   input  logic [DW-1:0]   i_cmd_dat,
   input  logic [DW/8-1:0] i_cmd_sel,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [DW-1:0]   o_rsp_dat,
   output logic [1:0]      o_rsp_status,
   output logic            o_wbm_cyc,
   output logic            o_wbm_stb,
   output logic            o_wbm_we,
   output logic [DW/8-1:0] o_wbm_sel,
   output logic [AW-1:0]   o_wbm_adr,
   output logic [DW-1:0]   o_wbm_dat,
   input  logic            i_wbm_ack,
   input  logic            i_wbm_err,
   input  logic [DW-1:0]   i_wbm_dat
);

   localparam int unsigned SW      = DW / 8;
   localparam bit          TO_EN   = (TIMEOUT != 0);
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
   logic [1:0]      rsp_status_q, rsp_status_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done;

   // State register and all registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= ST_OK;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      stb_d        = stb_q;
      we_d         = we_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      cnt_d        = cnt_q;
      done         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               we_d    = i_cmd_we;
               adr_d   = i_cmd_adr;
               dat_d   = i_cmd_dat;
               sel_d   = i_cmd_sel;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            // ERR wins over a simultaneous ACK; timeout only when neither arrived.
            if (i_wbm_err) begin
               done         = 1'b1;
               rsp_status_d = ST_ERR;
               rsp_dat_d    = '0;
            end else if (i_wbm_ack) begin
               done         = 1'b1;
               rsp_status_d = ST_OK;
               rsp_dat_d    = we_q ? '0 : i_wbm_dat;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               done         = 1'b1;
               rsp_status_d = ST_TMO;
               rsp_dat_d    = '0;
            end
            if (done) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Ready is held low while reset is asserted even though the state is IDLE.
   assign o_cmd_ready  = (state_q == S_IDLE) && i_rst_n;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_dat    = rsp_dat_q;
   assign o_rsp_status = rsp_status_q;
   assign o_wbm_cyc    = cyc_q;
   assign o_wbm_stb    = stb_q;
   assign o_wbm_we     = we_q;
   assign o_wbm_sel    = sel_q;
   assign o_wbm_adr    = adr_q;
   assign o_wbm_dat    = dat_q;

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic (B3, non-pipelined) initiator; the bus-master counterpart to the Wishbone slave port on the Modbus register-space controller.
- Converts single-beat commands on a valid/ready command port into one Wishbone read or write cycle.
- Returns read data plus a status code on a valid/ready response port.
- Used for on-chip self-test, and as the master side of UART-to-register-space bring-up paths. One transaction outstanding at a time; bus-timeout protected.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 255, maximum BUS-state cycles without ack/err before abort; 0 disables timeout.
- CW, 8, timeout counter width; must satisfy TIMEOUT < 2**CW.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  bridge can accept a command.
- i_cmd_we  input  1  1 = write, 0 = read.
- i_cmd_adr  input  AW  byte address.
- i_cmd_dat  input  DW  write data.
- i_cmd_sel  input  DW/8  byte enables.
- o_rsp_valid  output  1  response present.
- i_rsp_ready  input  1  response consumed.
- o_rsp_dat  output  DW  read data; 0 for writes and failed cycles.
- o_rsp_status  output  2  00 OK, 01 bus error, 10 timeout, 11 reserved.
- o_wbm_cyc  output  1  Wishbone CYC.
- o_wbm_stb  output  1  Wishbone STB.
- o_wbm_we  output  1  Wishbone WE.
- o_wbm_sel  output  DW/8  Wishbone SEL.
- o_wbm_adr  output  AW  Wishbone ADR.
- o_wbm_dat  output  DW  Wishbone write data.
- i_wbm_ack  input  1  Wishbone ACK.
- i_wbm_err  input  1  Wishbone ERR.
- i_wbm_dat  input  DW  Wishbone read data.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_wbm_cyc, o_wbm_stb, o_wbm_we = 0; o_wbm_sel, o_wbm_adr, o_wbm_dat = 0; o_rsp_valid = 0; o_rsp_dat = 0; o_rsp_status = 00; timeout counter = 0; o_cmd_ready = 0 while in reset.
- All outputs are registered, except o_cmd_ready, which is decoded from the state.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid & o_cmd_ready at edge N: latch we/adr/dat/sel onto the o_wbm_* outputs; set cyc = stb = 1; go to BUS. CYC/STB are therefore high in cycle N+1.
- BUS:
  - o_cmd_ready = 0. Counter increments every cycle in BUS, starting at 0 in the first BUS cycle.
  - i_wbm_err sampled high: status 01, rsp_dat 0. ERR takes priority over a simultaneous ACK.
  - Else i_wbm_ack sampled high: status 00; rsp_dat = i_wbm_dat for a read, 0 for a write.
  - Else counter == TIMEOUT-1 with TIMEOUT != 0: status 10, rsp_dat 0.
  - On any of these three terminations: at the same edge clear cyc/stb/we, set o_rsp_valid = 1, clear the counter, go to RESP. Ack at edge M therefore gives o_rsp_valid high and CYC low in cycle M+1.
  - Minimum command-to-response latency is 2 cycles (ack in the first BUS cycle).
  - ADR/DAT/SEL hold their values until the next command is accepted.
- RESP:
  - o_rsp_valid, o_rsp_dat and o_rsp_status are held stable until i_rsp_ready.
  - On o_rsp_valid & i_rsp_ready: clear o_rsp_valid and go to IDLE. The next command is accepted no earlier than the following cycle.
- ACK/ERR in IDLE or RESP are ignored (spurious); no state or data change.
- A command presented while not ready is not consumed; the source must hold it.
- Reset asserted mid-BUS drops CYC/STB asynchronously. No response is generated for the aborted transaction.
- Timeout counter saturates and never wraps. With TIMEOUT = 0 the bridge waits indefinitely.

Test Plan:
1. Write then read (zero-wait slave acking in the first STB cycle): write adr 0x3000_0004, dat 0xDEAD_BEEF, sel 0xF → CYC/STB high exactly 1 cycle, WE = 1, response status 00, dat 0. Then read the same address → o_rsp_dat 0xDEAD_BEEF, status 00, 2 cycles command-to-rsp_valid.
2. Wait states: slave delays ACK 5 cycles, read returns 0x1234_5678 → CYC/STB high 6 cycles, ADR stable throughout, rsp 0x1234_5678 / 00.
3. Timeout: TIMEOUT = 8, slave never acks → CYC drops after exactly 8 BUS cycles, status 10, dat 0. A later ACK pulse in IDLE → no response generated.
4. Error priority: ACK and ERR asserted together on a read with i_wbm_dat = 0xFFFF_FFFF → status 01, dat 0.
5. Backpressure: i_rsp_ready held low 10 cycles after completion → rsp_valid, dat and status stable, o_cmd_ready = 0, a held i_cmd_valid not accepted. Once i_rsp_ready is raised, that command is accepted the cycle after the response handshake.
6. Reset mid-cycle: deassert i_rsp_n... specifically, drive i_rst_n low during the 3rd wait cycle of a write → CYC/STB/WE low immediately (asynchronous). After release, o_cmd_ready = 1, o_rsp_valid = 0, and a new read completes normally.
